// File: rtl/uio_bus_if.sv
// Bundles the requester handshake signals and the uio pad signals shared by
// uio_bus_arbiter and whatever drives it.
interface uio_bus_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   dir;
   logic [8*NREQ-1:0] wdata;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   grant;
   logic [7:0]        rdata;
   logic [7:0]        uio_in;
   logic [7:0]        uio_out;
   logic [7:0]        uio_oe;

   modport master (
      output req, dir, wdata, uio_in,
      input  ack, grant, rdata, uio_out, uio_oe
   );

   modport slave (
      input  req, dir, wdata, uio_in,
      output ack, grant, rdata, uio_out, uio_oe
   );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pad bus between NREQ requesters,
// with a one-cycle turnaround on direction change and a capped burst length.
module uio_bus_arbiter #(
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     ena,
   uio_bus_if.slave bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic [1:0] {
      IDLE,
      TURN,
      XFER
   } state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
   logic            bus_dir_q, bus_dir_d;

   logic [IW-1:0]   g_idx;
   logic [IW-1:0]   win_idx;
   logic            win_found;
   logic [IW:0]     cand;
   logic            beat;

   // Owner index from the one-hot grant register.
   always_comb begin
      g_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_q[i]) g_idx = IW'(i);
      end
   end

   // First asserted request scanning upward from rr_ptr, wrapping modulo NREQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
         if (!win_found && bus.req[cand[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IW-1:0];
         end
      end
   end

   // A beat is consumed only while the owner still wants the current direction
   // and reset is not being taken at this edge.
   assign beat = (state_q == XFER) && rst_n && ena &&
                 bus.req[g_idx] && (bus.dir[g_idx] == bus_dir_q);

   assign bus.ack     = beat ? grant_q : '0;
   assign bus.grant   = grant_q;
   assign bus.rdata   = (beat && !bus_dir_q) ? bus.uio_in : 8'h00;
   assign bus.uio_out = (beat && bus_dir_q) ? bus.wdata[{g_idx, 3'b000} +: 8] : 8'h00;
   assign bus.uio_oe  = (state_q != TURN && bus_dir_q) ? 8'hFF : 8'h00;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case
      // leaves a variable unassigned, which would infer a latch.
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      bus_dir_d  = bus_dir_q;

      if (!ena) begin
         state_d   = IDLE;
         grant_d   = '0;
         bus_dir_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               grant_d = '0;
               if (win_found) begin
                  grant_d    = NREQ'(1) << win_idx;
                  rr_ptr_d   = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + IW'(1);
                  beat_cnt_d = '0;
                  state_d    = (bus.dir[win_idx] != bus_dir_q) ? TURN : XFER;
               end
            end
            TURN: begin
               // Only entered when the winner's direction differs, so flip.
               bus_dir_d = ~bus_dir_q;
               state_d   = XFER;
            end
            XFER: begin
               if (beat) begin
                  if (beat_cnt_q == CW'(MAX_BURST-1)) begin
                     state_d = IDLE;
                     grant_d = '0;
                  end else begin
                     beat_cnt_d = beat_cnt_q + CW'(1);
                  end
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end
            default: begin
               state_d = IDLE;
               grant_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values of the others.
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         bus_dir_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         bus_dir_q  <= bus_dir_d;
      end
   end

endmodule

// File: doc/uio_bus_arbiter.md
Name: uio_bus_arbiter

Overview:
- Shares the 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) of the tt_um_madeesha top level between NREQ internal requesters.
- Each requester asks for read beats (sample uio_in) or write beats (drive uio_out).
- The block arbitrates round-robin, inserts a one-cycle bus turnaround on every direction change, and caps burst length so no requester starves the others.
- Instantiated inside the user project, between the core logic and the uio pins.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum consecutive beats per grant (1..16).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  design enable; low = no new grants, bus released.
- req  input  NREQ  per-requester request, held high while beats are wanted.
- dir  input  NREQ  per-requester direction: 1 = write (drive pads), 0 = read.
- wdata  input  8*NREQ  write data; requester i uses bits [8i+7:8i].
- ack  output  NREQ  one-hot; beat consumed at this clock edge (combinational).
- rdata  output  8  read data, valid when ack is high for a read beat.
- grant  output  NREQ  one-hot registered owner of the bus; 0 when idle.
- uio_in  input  8  pad input path.
- uio_out  output  8  pad output path.
- uio_oe  output  8  pad enable; 8'hFF = drive, 8'h00 = input.

Behaviour:
- Reset (rst_n low at an edge):
  - state=IDLE, grant=0, uio_oe=8'h00, bus_dir=read.
  - rr_ptr=0, beat_cnt=0.
  - Combinational outputs in reset state: ack=0, uio_out=8'h00.
- Reset applied mid-burst aborts the burst immediately; the current cycle's beat completes only if rst_n is high at that edge.
- State IDLE:
  - uio_oe holds its parked value (last driven direction).
  - If ena and any req: winner = first asserted req scanning from rr_ptr upward, wrapping modulo NREQ.
  - At the edge: grant <= onehot(winner), rr_ptr <= (winner+1) mod NREQ, beat_cnt <= 0.
  - Next state: TURN if dir[winner] differs from bus_dir, else XFER.
- State TURN:
  - Exactly 1 cycle; uio_oe forced 8'h00, ack=0.
  - bus_dir <= dir[winner]; next state XFER.
- State XFER, with g = grant index:
  - beat = req[g] and (dir[g]==bus_dir) and ena.
  - On a beat: ack[g]=1. Write: uio_out=wdata[g], uio_oe=8'hFF. Read: rdata=uio_in, uio_oe=8'h00.
  - On each beat, beat_cnt increments. When it reaches MAX_BURST-1 on a beat, next state is IDLE.
  - If beat is false (req dropped, dir flipped, or ena low): no ack, next state IDLE, grant <= 0.
  - Entering IDLE from XFER clears grant.
- Latency:
  - Request to first ack: 1 cycle (IDLE→XFER) with no turnaround, 2 cycles with turnaround.
  - Each re-arbitration costs 1 IDLE cycle.
- Same requester winning again in the same direction skips TURN.
- ena low in any state: next state IDLE, uio_oe <= 8'h00, bus_dir <= read.
- Outputs when not in a write beat: uio_out=8'h00, rdata=8'h00 outside read beats, ack never asserted outside XFER.
- Simultaneous requests resolve purely by rr_ptr. After reset, requester 0 has highest priority.

Test Plan:
- Reset, then req=4'b0001, dir=0, uio_in=8'hA5 held: grant=0001 one cycle later; ack[0] high for exactly 4 consecutive cycles with rdata=8'hA5 and uio_oe=00; then 1 IDLE cycle; then re-grant to requester 0.
- req[1] write, wdata1=8'h3C, bus parked read: 1 IDLE cycle, then TURN with uio_oe=00, then 4 beats with uio_out=3C, uio_oe=FF. After the burst uio_oe stays FF in IDLE.
- req=4'b1111, all read, held: grants rotate 0,1,2,3,0, each with 4 beats; no requester gets 2 consecutive bursts.
- Requester 2 drops req after 2 beats: exactly 2 acks, then grant=0 and IDLE; pending req[3] is granted next.
- ena pulled low during a write burst: no ack that cycle, next cycle uio_oe=00 and grant=0. With ena high again, the next write grant inserts a TURN cycle.
- rst_n low for 1 cycle during XFER: the following cycle shows grant=0, uio_oe=00, ack=0, and requester 0 has priority again.
